// File: rtl/seg_display_reader.sv
// Samples an asynchronous 7-segment bus, waits for it to hold steady, and decodes it back into
// digit/blank/dash/invalid; strobes once per newly accepted symbol, with a saturating count and a sticky error flag.
module seg_display_reader #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       cc_in,
  input  logic       clr_err,
  output logic       sym_valid,
  output logic [1:0] sym_class,
  output logic [3:0] sym_digit,
  output logic [7:0] sym_count,
  output logic       err_sticky
);

  localparam logic [1:0] CLS_DIGIT = 2'b00;
  localparam logic [1:0] CLS_BLANK = 2'b01;
  localparam logic [1:0] CLS_DASH  = 2'b10;
  localparam logic [1:0] CLS_INVAL = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  // The accepting sample is the one that brings the run to STABLE_CYCLES-1, so the strobe
  // is registered STABLE_CYCLES+2 edges after the pins settle.
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 2);

  logic [7:0]       s1;
  logic [7:0]       s2;
  logic [7:0]       prev;
  logic [CNT_W-1:0] cnt;
  logic             have_last;
  logic [5:0]       last_sym;

  logic             same;
  logic             accept;
  logic             new_sym;
  logic [6:0]       lit;
  logic [1:0]       dec_class;
  logic [3:0]       dec_digit;

  always_comb begin
    same   = (s2 == prev);
    accept = same && (cnt == CNT_ACC);
    lit    = s2[7] ? s2[6:0] : ~s2[6:0];
  end

  always_comb begin
    dec_class = CLS_DIGIT;
    dec_digit = 4'd0;
    case (lit)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      7'h00: dec_class = CLS_BLANK;
      7'h40: dec_class = CLS_DASH;
      default: dec_class = CLS_INVAL;
    endcase
  end

  // Compare the decoded symbol rather than raw pins, so a polarity flip showing the same glyph is not new.
  always_comb begin
    new_sym = accept && (!have_last || ({dec_class, dec_digit} != last_sym));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= '0;
      s2         <= '0;
      prev       <= '0;
      cnt        <= '0;
      have_last  <= 1'b0;
      last_sym   <= '0;
      sym_valid  <= 1'b0;
      sym_class  <= '0;
      sym_digit  <= '0;
      sym_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      s1   <= {cc_in, seg_in};
      s2   <= s1;
      prev <= s2;

      if (!same) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end

      sym_valid <= new_sym;
      if (new_sym) begin
        last_sym  <= {dec_class, dec_digit};
        have_last <= 1'b1;
        sym_class <= dec_class;
        sym_digit <= dec_digit;
        if (sym_count != 8'hFF) begin
          sym_count <= sym_count + 8'd1;
        end
      end

      if (new_sym && (dec_class == CLS_INVAL)) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed bench for seg_display_reader with STABLE_CYCLES=4: latency, polarity, glitches, errors, saturation, reset.
module tb_seg_display_reader;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       cc_in;
  logic       clr_err;
  logic       sym_valid;
  logic [1:0] sym_class;
  logic [3:0] sym_digit;
  logic [7:0] sym_count;
  logic       err_sticky;

  int n_vec;
  int n_bad;
  int first_edge;
  int n_strobe;

  seg_display_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .cc_in      (cc_in),
    .clr_err    (clr_err),
    .sym_valid  (sym_valid),
    .sym_class  (sym_class),
    .sym_digit  (sym_digit),
    .sym_count  (sym_count),
    .err_sticky (err_sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a pattern and hold it for 'hold' edges; edge 1 is the first posedge after the call.
  task automatic drive_hold(input logic cc, input logic [6:0] seg, input int hold);
    cc_in      = cc;
    seg_in     = seg;
    first_edge = 0;
    n_strobe   = 0;
    for (int e = 1; e <= hold; e++) begin
      @(posedge clk);
      #1;
      if (sym_valid) begin
        n_strobe++;
        if (first_edge == 0) first_edge = e;
      end
    end
  endtask

  initial begin
    int bad_cls;
    int total;
    n_vec   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    clr_err = 1'b0;
    cc_in   = 1'b1;
    seg_in  = 7'h06;

    #23;
    chk("rst_valid", 32'(sym_valid), 32'd0);
    chk("rst_class", 32'(sym_class), 32'd0);
    chk("rst_digit", 32'(sym_digit), 32'd0);
    chk("rst_count", 32'(sym_count), 32'd0);
    chk("rst_err",   32'(err_sticky), 32'd0);
    #4 rst_n = 1'b1;

    // 1: digit 1, common cathode, full latency
    drive_hold(1'b1, 7'h06, 10);
    chk("t1_edge",   32'(first_edge), 32'd6);
    chk("t1_nstb",   32'(n_strobe), 32'd1);
    chk("t1_class",  32'(sym_class), 32'd0);
    chk("t1_digit",  32'(sym_digit), 32'd1);
    chk("t1_count",  32'(sym_count), 32'd1);

    // 2: common anode 5, then same glyph in common cathode
    drive_hold(1'b0, 7'h12, 10);
    chk("t2_edge",   32'(first_edge), 32'd6);
    chk("t2_digit",  32'(sym_digit), 32'd5);
    chk("t2_class",  32'(sym_class), 32'd0);
    chk("t2_count",  32'(sym_count), 32'd2);
    drive_hold(1'b1, 7'h6D, 12);
    chk("t2_flip_nstb",  32'(n_strobe), 32'd0);
    chk("t2_flip_count", 32'(sym_count), 32'd2);

    // 3: glitch rejection
    drive_hold(1'b1, 7'h4F, 10);
    chk("t3_digit",  32'(sym_digit), 32'd3);
    chk("t3_count",  32'(sym_count), 32'd3);
    drive_hold(1'b1, 7'h7F, 3);
    chk("t3_glitch_nstb", 32'(n_strobe), 32'd0);
    drive_hold(1'b1, 7'h4F, 10);
    chk("t3_back_nstb",   32'(n_strobe), 32'd0);
    chk("t3_back_digit",  32'(sym_digit), 32'd3);
    drive_hold(1'b1, 7'h7F, 20);
    chk("t3_long_nstb",   32'(n_strobe), 32'd1);
    chk("t3_long_edge",   32'(first_edge), 32'd6);
    chk("t3_long_digit",  32'(sym_digit), 32'd8);
    chk("t3_long_count",  32'(sym_count), 32'd4);

    // 4: invalid pattern and sticky error
    drive_hold(1'b1, 7'h49, 10);
    chk("t4_class",  32'(sym_class), 32'd3);
    chk("t4_digit",  32'(sym_digit), 32'd0);
    chk("t4_err",    32'(err_sticky), 32'd1);
    chk("t4_count",  32'(sym_count), 32'd5);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("t4_clr_alone1", 32'(err_sticky), 32'd0);
    drive_hold(1'b1, 7'h07, 10);
    chk("t4_d7_digit", 32'(sym_digit), 32'd7);
    chk("t4_d7_err",   32'(err_sticky), 32'd0);
    cc_in  = 1'b1;
    seg_in = 7'h36;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_pre_valid", 32'(sym_valid), 32'd0);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("t4_set_valid", 32'(sym_valid), 32'd1);
    chk("t4_set_class", 32'(sym_class), 32'd3);
    chk("t4_set_wins",  32'(err_sticky), 32'd1);
    chk("t4_set_count", 32'(sym_count), 32'd7);
    repeat (3) @(posedge clk);
    #1;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    chk("t4_clr_alone2", 32'(err_sticky), 32'd0);

    // 5: blank/dash alternation to saturation
    bad_cls = 0;
    total   = 0;
    for (int i = 0; i < 300; i++) begin
      drive_hold(1'b1, (i % 2 == 0) ? 7'h00 : 7'h40, 10);
      total += n_strobe;
      if (sym_class != ((i % 2 == 0) ? 2'b01 : 2'b10)) bad_cls++;
    end
    chk("t5_strobes",   32'(total), 32'd300);
    chk("t5_class_alt", 32'(bad_cls), 32'd0);
    chk("t5_count_sat", 32'(sym_count), 32'd255);
    chk("t5_err",       32'(err_sticky), 32'd0);

    // 6: reset mid-count, re-accept at full latency
    drive_hold(1'b1, 7'h5B, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(sym_valid), 32'd0);
    chk("t6_rst_class", 32'(sym_class), 32'd0);
    chk("t6_rst_count", 32'(sym_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_hold(1'b1, 7'h5B, 10);
    chk("t6_edge",  32'(first_edge), 32'd6);
    chk("t6_nstb",  32'(n_strobe), 32'd1);
    chk("t6_digit", 32'(sym_digit), 32'd2);
    chk("t6_class", 32'(sym_class), 32'd0);
    chk("t6_count", 32'(sym_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
